axi_slave_mem: RTL
==================

Name: axi_slave_mem

Overview:
AXI3-style slave responder that terminates the five channels driven by the testbench BFM. It backs a word-addressed on-chip memory and serves write bursts (AW/W/B) and read bursts (AR/R) through independent state machines. Checks on burst type, size, ID, WLAST and address range drive the BRESP/RRESP codes. It is the DUT-side counterpart the bench drives and scoreboards against.

Parameters:
WIDTH, 32, data/address width; ID, LEN and STRB width = WIDTH/8
SIZE, 3, AxSIZE width; BURST/RESP width = SIZE-1
MEM_DEPTH, 256, memory depth in WIDTH-bit words (power of 2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
AWVALID/AWREADY  in/out  1  write address handshake
AWID, AWLEN  in  WIDTH/8  write ID; beats-1
AWADDR  in  WIDTH  byte address of first beat
AWSIZE  in  SIZE  bytes/beat encoding
AWBURST  in  SIZE-1  00 FIXED, 01 INCR, 10 WRAP
WVALID/WREADY  in/out  1  write data handshake
WID, WSTRB  in  WIDTH/8  data ID; byte enables
WDATA  in  WIDTH  write data
WLAST  in  1  final write beat
BVALID/BREADY  out/in  1  write response handshake
BID  out  WIDTH/8  = captured AWID
BRESP  out  SIZE-1  00 OKAY, 10 SLVERR, 11 DECERR
ARVALID/ARREADY  in/out  1  read address handshake
ARID, ARLEN  in  WIDTH/8  read ID; beats-1
ARADDR  in  WIDTH  byte address of first beat
ARSIZE  in  SIZE  bytes/beat
ARBURST  in  SIZE-1  burst type
RVALID/RREADY  out/in  1  read data handshake
RID  out  WIDTH/8  = captured ARID
RDATA  out  WIDTH  read data
RRESP  out  SIZE-1  per-beat response
RLAST  out  1  final read beat

Behaviour:
- Reset (reset=0 at rising edge): all outputs 0; both FSMs to IDLE; beat counters 0; memory contents untouched. Reset mid-burst aborts it silently; no B/R completion issued.
- Handshake = VALID&&READY at rising edge. Outputs are registered. VALID, once high, stays high and payload stays stable until accepted.
- Write FSM: W_IDLE (AWREADY=1) -AW hs-> W_DATA (AWREADY=0, WREADY=1; AWID/ADDR/LEN/SIZE/BURST latched) -W hs on beat AWLEN-> W_RESP (WREADY=0, BVALID=1) -B hs-> W_IDLE. AWREADY first reaches 1 one cycle after reset release.
- Each accepted W beat: bytes with WSTRB[i]=1 are written to mem[addr[log2(MEM_DEPTH)+1:2]]. INCR adds 4 to addr per beat; FIXED holds addr.
- Beat count is AWLEN+1 regardless of WLAST. BRESP is sticky-worst over the burst. SLVERR if AWBURST is WRAP or 11, AWSIZE!=010, WID!=latched AWID, WLAST on a non-final beat, or WLAST missing on the final beat. DECERR if any beat addr >= 4*MEM_DEPTH. SLVERR conditions on AW suppress all memory writes for the burst; DECERR suppresses only the offending beat.
- Read FSM: R_IDLE (ARREADY=1) -AR hs-> R_DATA (ARREADY=0). RVALID rises the cycle after AR hs with beat 0. Each R hs advances to the next beat; a new beat is presented the next cycle, so back-to-back beats are possible with RREADY held high. RLAST=1 only on beat ARLEN. R hs with RLAST -> R_IDLE, RVALID=0.
- RRESP per beat: SLVERR (RDATA=0) for bad ARBURST/ARSIZE; DECERR (RDATA=0) for out-of-range addr; else OKAY.
- Write and read FSMs run concurrently. A same-word read fetch and write in the same cycle return the old data (read-before-write).
- Address LSBs [1:0] are ignored (aligned words only). The counter is LEN-width; LEN=15 gives 16 beats, with no wrap past the counter.

Test Plan:
- Reset, then AW{ID=3,ADDR=0x10,LEN=3,INCR,SIZE=010}, 4 beats 0xA0..0xA3 with WSTRB=F and WLAST on beat 3 -> BVALID with BID=3, BRESP=00; mem[4..7]=A0..A3.
- AR{ID=5,ADDR=0x10,LEN=3,INCR} with RREADY=1 -> RVALID 1 cycle after AR hs; 4 consecutive beats A0..A3; RID=5; RLAST on beat 3 only; RRESP=00.
- RREADY toggled 1/0 during the read -> RDATA/RLAST held stable while stalled; no beat lost or duplicated.
- Write with WSTRB=0101, WDATA=0xFFFFFFFF to a word holding 0x12345678 -> readback 0x12FF56FF.
- AWBURST=10 -> BRESP=10 and memory unchanged. ARADDR=4*MEM_DEPTH -> RRESP=11, RDATA=0. WID!=AWID -> BRESP=10.
- Assert reset=0 mid write burst (beat 1 of 4) -> WREADY/BVALID=0 next edge; AWREADY=1 one cycle after release; no B response issued.

Source files
------------

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI3-style slave backed by a word-addressed on-chip memory.
// Write bursts (AW/W/B) and read bursts (AR/R) run in independent FSMs.
// Ports:
//   clk, reset            : rising-edge clock, synchronous active-low reset
//   AW*                   : write address channel (ID, byte address, LEN, SIZE, BURST)
//   W*                    : write data channel (ID, data, byte strobes, LAST)
//   B*                    : write response channel (ID, RESP)
//   AR*                   : read address channel
//   R*                    : read data channel (ID, data, RESP, LAST)
// All outputs are registered.
module axi_slave_mem #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned SIZE      = 3,
   parameter int unsigned MEM_DEPTH = 256
) (
   input  logic                 clk,
   input  logic                 reset,
   // write address
   input  logic                 AWVALID,
   output logic                 AWREADY,
   input  logic [WIDTH/8-1:0]   AWID,
   input  logic [WIDTH/8-1:0]   AWLEN,
   input  logic [WIDTH-1:0]     AWADDR,
   input  logic [SIZE-1:0]      AWSIZE,
   input  logic [SIZE-2:0]      AWBURST,
   // write data
   input  logic                 WVALID,
   output logic                 WREADY,
   input  logic [WIDTH/8-1:0]   WID,
   input  logic [WIDTH/8-1:0]   WSTRB,
   input  logic [WIDTH-1:0]     WDATA,
   input  logic                 WLAST,
   // write response
   output logic                 BVALID,
   input  logic                 BREADY,
   output logic [WIDTH/8-1:0]   BID,
   output logic [SIZE-2:0]      BRESP,
   // read address
   input  logic                 ARVALID,
   output logic                 ARREADY,
   input  logic [WIDTH/8-1:0]   ARID,
   input  logic [WIDTH/8-1:0]   ARLEN,
   input  logic [WIDTH-1:0]     ARADDR,
   input  logic [SIZE-1:0]      ARSIZE,
   input  logic [SIZE-2:0]      ARBURST,
   // read data
   output logic                 RVALID,
   input  logic                 RREADY,
   output logic [WIDTH/8-1:0]   RID,
   output logic [WIDTH-1:0]     RDATA,
   output logic [SIZE-2:0]      RRESP,
   output logic                 RLAST
);

   localparam int unsigned IW    = WIDTH / 8;
   localparam int unsigned BW    = SIZE - 1;
   localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

   localparam logic [WIDTH-1:0] ADDR_LIMIT  = WIDTH'(4 * MEM_DEPTH);
   localparam logic [WIDTH-1:0] BEAT_BYTES  = WIDTH'(4);
   localparam logic [SIZE-1:0]  SIZE_WORD   = SIZE'(2);
   localparam logic [BW-1:0]    BURST_FIXED = BW'(0);
   localparam logic [BW-1:0]    BURST_INCR  = BW'(1);
   localparam logic [BW-1:0]    RESP_OKAY   = BW'(0);
   localparam logic [BW-1:0]    RESP_SLVERR = BW'(2);
   localparam logic [BW-1:0]    RESP_DECERR = BW'(3);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

   // Response codes are ordered so that the numerically larger one is worse.
   function automatic logic [BW-1:0] resp_max(input logic [BW-1:0] a, input logic [BW-1:0] b);
      return (a > b) ? a : b;
   endfunction

   logic [WIDTH-1:0] mem [MEM_DEPTH];

   // ---------------- write side ----------------
   w_state_t         w_state, w_state_nxt;
   logic             aw_rdy_nxt, w_rdy_nxt, b_vld_nxt;
   logic [IW-1:0]    b_id_nxt;
   logic [BW-1:0]    b_resp_nxt;
   logic [IW-1:0]    w_id, w_id_nxt, w_len, w_len_nxt, w_cnt, w_cnt_nxt;
   logic [WIDTH-1:0] w_addr, w_addr_nxt;
   logic             w_incr, w_incr_nxt, w_sup, w_sup_nxt;
   logic [BW-1:0]    w_resp, w_resp_nxt;
   logic             aw_bad, w_oob, w_last, mem_we;
   logic [BW-1:0]    beat_resp;
   logic [IDX_W-1:0] mem_widx;

   assign aw_bad = !((AWBURST == BURST_FIXED) || (AWBURST == BURST_INCR)) || (AWSIZE != SIZE_WORD);

   // Write FSM next-state and registered-output values
   always_comb begin
      w_state_nxt = w_state;
      aw_rdy_nxt  = AWREADY;
      w_rdy_nxt   = WREADY;
      b_vld_nxt   = BVALID;
      b_id_nxt    = BID;
      b_resp_nxt  = BRESP;
      w_id_nxt    = w_id;
      w_len_nxt   = w_len;
      w_cnt_nxt   = w_cnt;
      w_addr_nxt  = w_addr;
      w_incr_nxt  = w_incr;
      w_sup_nxt   = w_sup;
      w_resp_nxt  = w_resp;
      mem_we      = 1'b0;
      mem_widx    = w_addr[IDX_W+1:2];
      w_oob       = (w_addr >= ADDR_LIMIT);
      w_last      = (w_cnt == w_len);

      // accumulated response including the beat currently on the bus
      beat_resp = w_resp;
      if ((WID != w_id) || (WLAST != w_last)) beat_resp = resp_max(beat_resp, RESP_SLVERR);
      if (w_oob)                              beat_resp = resp_max(beat_resp, RESP_DECERR);

      case (w_state)
         W_IDLE: begin
            aw_rdy_nxt = 1'b1;
            if (AWVALID && AWREADY) begin
               w_state_nxt = W_DATA;
               aw_rdy_nxt  = 1'b0;
               w_rdy_nxt   = 1'b1;
               w_id_nxt    = AWID;
               w_len_nxt   = AWLEN;
               w_addr_nxt  = AWADDR;
               w_incr_nxt  = (AWBURST == BURST_INCR);
               w_cnt_nxt   = '0;
               w_sup_nxt   = aw_bad;
               w_resp_nxt  = aw_bad ? RESP_SLVERR : RESP_OKAY;
            end
         end
         W_DATA: begin
            if (WVALID && WREADY) begin
               // bad AW suppresses the whole burst; out-of-range only this beat
               mem_we     = !w_sup && !w_oob;
               w_resp_nxt = beat_resp;
               w_cnt_nxt  = w_cnt + IW'(1);
               w_addr_nxt = w_incr ? (w_addr + BEAT_BYTES) : w_addr;
               if (w_last) begin
                  w_state_nxt = W_RESP;
                  w_rdy_nxt   = 1'b0;
                  b_vld_nxt   = 1'b1;
                  b_id_nxt    = w_id;
                  b_resp_nxt  = beat_resp;
               end
            end
         end
         W_RESP: begin
            if (BVALID && BREADY) begin
               w_state_nxt = W_IDLE;
               b_vld_nxt   = 1'b0;
               aw_rdy_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   // ---------------- read side ----------------
   r_state_t         r_state, r_state_nxt;
   logic             ar_rdy_nxt, r_vld_nxt, r_last_nxt;
   logic [IW-1:0]    r_id_nxt;
   logic [WIDTH-1:0] r_data_nxt;
   logic [BW-1:0]    r_resp_nxt;
   logic [IW-1:0]    r_len, r_len_nxt, r_cnt, r_cnt_nxt;
   logic [WIDTH-1:0] r_addr, r_addr_nxt;
   logic             r_incr, r_incr_nxt, r_bad, r_bad_nxt;
   logic             ar_bad, fetch_bad;
   logic [WIDTH-1:0] fetch_addr, fetch_data;
   logic [BW-1:0]    fetch_resp;

   assign ar_bad = !((ARBURST == BURST_FIXED) || (ARBURST == BURST_INCR)) || (ARSIZE != SIZE_WORD);

   // Address and data of the beat to be presented after the next edge
   always_comb begin
      if (r_state == R_IDLE) begin
         fetch_addr = ARADDR;
         fetch_bad  = ar_bad;
      end else begin
         fetch_addr = r_incr ? (r_addr + BEAT_BYTES) : r_addr;
         fetch_bad  = r_bad;
      end
      fetch_data = '0;
      fetch_resp = RESP_OKAY;
      if (fetch_bad) begin
         fetch_resp = RESP_SLVERR;
      end else if (fetch_addr >= ADDR_LIMIT) begin
         fetch_resp = RESP_DECERR;
      end else begin
         fetch_data = mem[fetch_addr[IDX_W+1:2]];
      end
   end

   // Read FSM next-state and registered-output values
   always_comb begin
      r_state_nxt = r_state;
      ar_rdy_nxt  = ARREADY;
      r_vld_nxt   = RVALID;
      r_id_nxt    = RID;
      r_data_nxt  = RDATA;
      r_resp_nxt  = RRESP;
      r_last_nxt  = RLAST;
      r_len_nxt   = r_len;
      r_cnt_nxt   = r_cnt;
      r_addr_nxt  = r_addr;
      r_incr_nxt  = r_incr;
      r_bad_nxt   = r_bad;

      case (r_state)
         R_IDLE: begin
            ar_rdy_nxt = 1'b1;
            if (ARVALID && ARREADY) begin
               r_state_nxt = R_DATA;
               ar_rdy_nxt  = 1'b0;
               r_vld_nxt   = 1'b1;
               r_id_nxt    = ARID;
               r_len_nxt   = ARLEN;
               r_incr_nxt  = (ARBURST == BURST_INCR);
               r_bad_nxt   = ar_bad;
               r_addr_nxt  = ARADDR;
               r_cnt_nxt   = '0;
               r_last_nxt  = (ARLEN == '0);
               r_data_nxt  = fetch_data;
               r_resp_nxt  = fetch_resp;
            end
         end
         R_DATA: begin
            if (RVALID && RREADY) begin
               if (RLAST) begin
                  r_state_nxt = R_IDLE;
                  r_vld_nxt   = 1'b0;
                  r_last_nxt  = 1'b0;
                  ar_rdy_nxt  = 1'b1;
               end else begin
                  r_cnt_nxt  = r_cnt + IW'(1);
                  r_addr_nxt = fetch_addr;
                  r_last_nxt = ((r_cnt + IW'(1)) == r_len);
                  r_data_nxt = fetch_data;
                  r_resp_nxt = fetch_resp;
               end
            end
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   // State and output registers for both channels
   always_ff @(posedge clk) begin
      if (!reset) begin
         w_state <= W_IDLE;
         AWREADY <= 1'b0;
         WREADY  <= 1'b0;
         BVALID  <= 1'b0;
         BID     <= '0;
         BRESP   <= '0;
         w_id    <= '0;
         w_len   <= '0;
         w_cnt   <= '0;
         w_addr  <= '0;
         w_incr  <= 1'b0;
         w_sup   <= 1'b0;
         w_resp  <= '0;
         r_state <= R_IDLE;
         ARREADY <= 1'b0;
         RVALID  <= 1'b0;
         RID     <= '0;
         RDATA   <= '0;
         RRESP   <= '0;
         RLAST   <= 1'b0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_incr  <= 1'b0;
         r_bad   <= 1'b0;
      end else begin
         w_state <= w_state_nxt;
         AWREADY <= aw_rdy_nxt;
         WREADY  <= w_rdy_nxt;
         BVALID  <= b_vld_nxt;
         BID     <= b_id_nxt;
         BRESP   <= b_resp_nxt;
         w_id    <= w_id_nxt;
         w_len   <= w_len_nxt;
         w_cnt   <= w_cnt_nxt;
         w_addr  <= w_addr_nxt;
         w_incr  <= w_incr_nxt;
         w_sup   <= w_sup_nxt;
         w_resp  <= w_resp_nxt;
         r_state <= r_state_nxt;
         ARREADY <= ar_rdy_nxt;
         RVALID  <= r_vld_nxt;
         RID     <= r_id_nxt;
         RDATA   <= r_data_nxt;
         RRESP   <= r_resp_nxt;
         RLAST   <= r_last_nxt;
         r_len   <= r_len_nxt;
         r_cnt   <= r_cnt_nxt;
         r_addr  <= r_addr_nxt;
         r_incr  <= r_incr_nxt;
         r_bad   <= r_bad_nxt;
      end
   end

   // Byte-enabled memory write; contents survive reset
   always_ff @(posedge clk) begin
      if (reset && mem_we) begin
         for (int i = 0; i < int'(IW); i++) begin
            if (WSTRB[i]) mem[mem_widx][8*i +: 8] <= WDATA[8*i +: 8];
         end
      end
   end

endmodule
